// File: rtl/shift_register_sequencer.sv
// shift_register_sequencer
//   Loads words into an external serial-in/parallel-out shift register
//   MSB-first, one bit per clock. After WIDTH shifts it compares the
//   register's parallel output with the word sent and reports done/match.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data   word handshake (ready only while idle)
//   serial_out     registered bit driven into the shift register
//   shift_active   high while frame bits are on serial_out
//   parallel_in    shift register parallel output
//   busy           high whenever a frame is in flight
//   done           one-cycle pulse when the frame check completes
//   match          check result, held until the next done
//   err_cnt        saturating mismatch counter (SHIFT_SEQ_ERR_CNT_EN only)
//
// Optional feature macro: SHIFT_SEQ_ERR_CNT_EN
module shift_register_sequencer #(
    parameter int unsigned WIDTH      = 8,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SHIFT_SEQ_ERR_CNT_EN
    output logic [7:0]       err_cnt,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             serial_out,
    output logic             shift_active,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             busy,
    output logic             done,
    output logic             match
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             serial_q, serial_d;
    logic             active_q, active_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             match_q, match_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            word_q   <= '0;
            serial_q <= IDLE_LEVEL;
            active_q <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            serial_q <= serial_d;
            active_q <= active_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            match_q  <= match_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        serial_d = serial_q;
        active_d = active_q;
        done_d   = 1'b0;
        match_d  = match_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    word_d   = in_data;
                    cnt_d    = CNT_W'(WIDTH - 1);
                    serial_d = in_data[WIDTH-1];
                    active_d = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // cnt indexes the bit currently on serial_out; 0 means the LSB is out
                if (cnt_q != '0) begin
                    cnt_d    = cnt_q - CNT_W'(1);
                    serial_d = word_q[cnt_d];
                end else begin
                    serial_d = IDLE_LEVEL;
                    active_d = 1'b0;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // register now holds the full frame shifted in on the previous edge
                match_d = (parallel_in == word_q);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    assign in_ready     = ready_q;
    assign busy         = busy_q;
    assign serial_out   = serial_q;
    assign shift_active = active_q;
    assign done         = done_q;
    assign match        = match_q;

`ifdef SHIFT_SEQ_ERR_CNT_EN
    logic [7:0] err_q, err_d;

    // Saturating count of failed frame checks
    always_comb begin
        err_d = err_q;
        if ((state_q == ST_CHECK) && (parallel_in != word_q) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt = err_q;
`else
    // No mismatch counter in this build.
`endif

endmodule

// File: tb/tb_shift_register_sequencer.sv
// Bench for shift_register_sequencer: a real SIPO register (with a stub
// override) on parallel_in, a time-since-accept reference model checked
// every cycle, plus directed literal checks.
module tb_shift_register_sequencer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         serial_out;
    logic         shift_active;
    logic [W-1:0] parallel_in;
    logic         busy;
    logic         done;
    logic         match;
    logic [7:0]   err_obs;

    logic         stub_en = 1'b0;
    logic [W-1:0] stub_val = '0;
    logic [W-1:0] sr = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

`ifdef SHIFT_SEQ_ERR_CNT_EN
    logic [7:0] err_cnt;
    assign err_obs = err_cnt;
`else
    assign err_obs = 8'd0;
`endif

    shift_register_sequencer #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef SHIFT_SEQ_ERR_CNT_EN
        .err_cnt      (err_cnt),
`endif
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .serial_out   (serial_out),
        .shift_active (shift_active),
        .parallel_in  (parallel_in),
        .busy         (busy),
        .done         (done),
        .match        (match)
    );

    // Real serial-in/parallel-out register, optionally overridden by a stub
    always @(posedge clk) sr <= {sr[W-2:0], serial_out};
    assign parallel_in = stub_en ? stub_val : sr;

    // Reference model: frame described by edges elapsed since the accept edge
    int         m_age = -1;
    logic [W-1:0] m_word = '0;
    bit         m_done = 1'b0;
    bit         m_match = 1'b0;
    int         m_err = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_age   = -1;
            m_word  = '0;
            m_done  = 1'b0;
            m_match = 1'b0;
            m_err   = 0;
        end else begin
            m_done = 1'b0;
            if (m_age < 0) begin
                if (in_valid) begin
                    m_word = in_data;
                    m_age  = 0;
                end
            end else begin
                m_age = m_age + 1;
                if (m_age == W + 1) begin
                    m_done  = 1'b1;
                    m_match = (parallel_in == m_word);
                    if (!m_match && m_err < 255) m_err = m_err + 1;
                    m_age = -1;
                end
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        logic [13:0] exp_v;
        logic [13:0] act_v;
        logic        e_act;
        logic        e_ser;
        e_act = (m_age >= 0) && (m_age < W);
        e_ser = e_act ? m_word[W-1-m_age] : 1'b0;
`ifdef SHIFT_SEQ_ERR_CNT_EN
        exp_v = {m_age < 0, m_age >= 0, e_act, e_ser, m_done, m_match, 8'(m_err)};
`else
        exp_v = {m_age < 0, m_age >= 0, e_act, e_ser, m_done, m_match, 8'd0};
`endif
        act_v = {in_ready, busy, shift_active, serial_out, done, match, err_obs};
        n_vec = n_vec + 1;
        if (act_v !== exp_v) begin
            n_err = n_err + 1;
            $display("FAIL model_cmp t=%0t got rdy/busy/act/ser/done/match/err=%b required %b",
                     $time, act_v, exp_v);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(ok), 32'd1);
    endtask

    initial begin
        logic [W-1:0] bits;
        logic [W-1:0] pin;

        // Reset with a pending word: nothing may be accepted
        in_valid = 1'b1;
        in_data  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ready", 32'(in_ready), 32'd1);
            check("rst_serial", 32'(serial_out), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
        end
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);

        // 8'hB3 through the real register
        in_valid = 1'b1;
        in_data  = 8'hB3;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            bits[W-1-k] = serial_out;
            tick();
        end
        pin = parallel_in;
        check("b3_bits", 32'(bits), 32'hB3);
        check("b3_sample", 32'(pin), 32'hB3);
        check("b3_no_early_done", 32'(done), 32'd0);
        tick();
        check("b3_done", 32'(done), 32'd1);
        check("b3_match", 32'(match), 32'd1);

        // Stubbed register output 8'hB2 against sent 8'hB3
        stub_en  = 1'b1;
        stub_val = 8'hB2;
        in_valid = 1'b1;
        in_data  = 8'hB3;
        tick();
        in_valid = 1'b0;
        wait_done();
        check("stub_match", 32'(match), 32'd0);
`ifdef SHIFT_SEQ_ERR_CNT_EN
        check("stub_err_cnt", 32'(err_cnt), 32'd1);
`endif
        stub_en = 1'b0;
        tick();

        // Back-to-back frames with in_valid held high
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        wait_done();
        check("b2b_first_match", 32'(match), 32'd1);
        check("b2b_ready_at_done", 32'(in_ready), 32'd1);
        in_data = 8'h00;
        tick();
        check("b2b_second_accepted", 32'(busy), 32'd1);
        check("b2b_first_bit", 32'(serial_out), 32'd0);
        in_valid = 1'b0;
        wait_done();
        check("b2b_second_match", 32'(match), 32'd1);

        // in_data churn during SHIFT must not leak into the frame
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            in_data = 8'($urandom);
            tick();
        end
        tick();
        check("churn_done", 32'(done), 32'd1);
        check("churn_match", 32'(match), 32'd1);

        // Reset mid-frame, then a clean 8'h5A frame
        in_valid = 1'b1;
        in_data  = 8'hC7;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_serial", 32'(serial_out), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();
        check("midrst_idle_done", 32'(done), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        tick();
        in_valid = 1'b0;
        wait_done();
        check("5a_match", 32'(match), 32'd1);

        // Randomized traffic checked by the model
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 79) == 0);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            stub_en  = ($urandom_range(0, 5) == 0);
            stub_val = 8'($urandom);
            tick();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        stub_en  = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
